// File: rtl/elevator_weight_control.sv
// ---------------------------------------------------------------------------
// elevator_weight_control
//
// Overload detector for the elevator emergency subsystem. Counts rising
// edges of the weight_flip load-sensor pulse and raises a sticky
// weight_limit_exceeded flag once the count reaches THRESHOLD. The flag
// holds until reset and is used by the emergency controller to inhibit car
// motion and door close.
//
// Optional build macro:
//   WEIGHT_SYNC_EN - when defined, weight_flip passes through a 2-flop
//                    synchronizer (both stages reset to 1) before edge
//                    detection, adding 2 cycles of latency. When undefined,
//                    weight_flip feeds the edge detector directly.
//
// Parameters:
//   THRESHOLD - number of weight_flip rising edges that trips the flag
//               (legal range 1 .. 2**COUNT_W-1)
//   COUNT_W   - width of the edge counter
//
// Ports:
//   clk                   - single clock, all logic on its rising edge
//   reset_weight_flip     - asynchronous active-high reset
//   weight_flip           - load-sensor pulse, each 0->1 is one event
//   weight_limit_exceeded - registered sticky overload flag
//   weight_count          - registered event count, saturates at THRESHOLD
// ---------------------------------------------------------------------------
module elevator_weight_control #(
    parameter int THRESHOLD = 5,
    parameter int COUNT_W   = 3
) (
    input  logic               clk,
    input  logic               reset_weight_flip,
    input  logic               weight_flip,
    output logic               weight_limit_exceeded,
    output logic [COUNT_W-1:0] weight_count
);

    localparam logic [COUNT_W-1:0] THRESH = COUNT_W'(THRESHOLD);

    logic               flip_s;
    logic               flip_q;
    logic               flip_d;
    logic               flip_event;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic               flag_q;
    logic               flag_d;

`ifdef WEIGHT_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer for a sensor that is asynchronous to clk.
    // Both stages reset high so a level held high through reset release
    // does not look like a fresh rising edge.
    always_ff @(posedge clk or posedge reset_weight_flip) begin
        if (reset_weight_flip) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= weight_flip;
            sync2_q <= sync1_q;
        end
    end

    assign flip_s = sync2_q;
`else
    assign flip_s = weight_flip;
`endif

    // An event is a 0->1 transition of the sampled sensor. Falling edges
    // and held-high levels produce no event.
    assign flip_event = flip_s & ~flip_q;

    // Next-state logic: the counter saturates at THRESHOLD, and the flag is
    // set as soon as the next count reaches THRESHOLD, then stays set.
    always_comb begin
        flip_d  = flip_s;
        count_d = count_q;
        flag_d  = flag_q;
        if (flip_event && (count_q < THRESH)) begin
            count_d = count_q + 1'b1;
        end
        if (count_d == THRESH) begin
            flag_d = 1'b1;
        end
    end

    // State registers. flip_q resets high for the same reason as the
    // synchronizer stages: no spurious event right after reset release.
    always_ff @(posedge clk or posedge reset_weight_flip) begin
        if (reset_weight_flip) begin
            flip_q  <= 1'b1;
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            flip_q  <= flip_d;
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign weight_count          = count_q;
    assign weight_limit_exceeded = flag_q;

endmodule

// File: tb/tb_elevator_weight_control.sv
// ---------------------------------------------------------------------------
// tb_elevator_weight_control
//
// Directed testbench for elevator_weight_control. Drives the default
// configuration (THRESHOLD=5) and a THRESHOLD=1 instance from the same
// clock, reset and sensor input, and checks both against hand-computed
// expected values.
// ---------------------------------------------------------------------------
module tb_elevator_weight_control;

`ifdef WEIGHT_SYNC_EN
    localparam int EXTRA_LAT = 2;
`else
    localparam int EXTRA_LAT = 0;
`endif

    logic       clk;
    logic       reset_weight_flip;
    logic       weight_flip;
    logic       flag_a;
    logic [2:0] count_a;
    logic       flag_b;
    logic [2:0] count_b;

    int checks;
    int failures;

    elevator_weight_control #(
        .THRESHOLD(5),
        .COUNT_W  (3)
    ) dut (
        .clk                  (clk),
        .reset_weight_flip    (reset_weight_flip),
        .weight_flip          (weight_flip),
        .weight_limit_exceeded(flag_a),
        .weight_count         (count_a)
    );

    elevator_weight_control #(
        .THRESHOLD(1),
        .COUNT_W  (3)
    ) dut_t1 (
        .clk                  (clk),
        .reset_weight_flip    (reset_weight_flip),
        .weight_flip          (weight_flip),
        .weight_limit_exceeded(flag_b),
        .weight_count         (count_b)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One sensor pulse: high for one cycle, low for two, plus the
    // synchronizer latency so the result is visible when the task returns.
    task automatic applyStimulus();
        @(negedge clk) weight_flip = 1'b1;
        @(negedge clk) weight_flip = 1'b0;
        @(negedge clk);
        repeat (EXTRA_LAT) @(negedge clk);
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        weight_flip       = 1'b0;
        reset_weight_flip = 1'b1;

        // Reset for two cycles, then release.
        repeat (2) @(negedge clk);
        reset_weight_flip = 1'b0;
        @(negedge clk);
        checkOutput("reset_count", int'(count_a), 0);
        checkOutput("reset_flag", int'(flag_a), 0);
        checkOutput("reset_count_t1", int'(count_b), 0);
        checkOutput("reset_flag_t1", int'(flag_b), 0);

        // Five pulses: count 1..5, flag only on the fifth.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("pulse%0d_count", i), int'(count_a), i);
            checkOutput($sformatf("pulse%0d_flag", i), int'(flag_a), (i == 5) ? 1 : 0);
            if (i == 1) begin
                checkOutput("t1_first_count", int'(count_b), 1);
                checkOutput("t1_first_flag", int'(flag_b), 1);
            end
        end

        // Three more pulses: saturated and sticky.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus();
            checkOutput($sformatf("sat%0d_count", i), int'(count_a), 5);
            checkOutput($sformatf("sat%0d_flag", i), int'(flag_a), 1);
        end
        checkOutput("t1_sat_count", int'(count_b), 1);
        checkOutput("t1_sat_flag", int'(flag_b), 1);

        // Asynchronous reset between clock edges while the flag is set.
        @(posedge clk);
        #2 reset_weight_flip = 1'b1;
        #1;
        checkOutput("async_rst_count", int'(count_a), 0);
        checkOutput("async_rst_flag", int'(flag_a), 0);

        // Hold the sensor high across reset release: no count.
        @(negedge clk) weight_flip = 1'b1;
        @(negedge clk) reset_weight_flip = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("held_release_count", int'(count_a), 0);
        checkOutput("held_release_flag", int'(flag_a), 0);

        // Falling then rising again is counted.
        @(negedge clk) weight_flip = 1'b0;
        repeat (EXTRA_LAT) @(negedge clk);
        applyStimulus();
        checkOutput("refall_count", int'(count_a), 1);
        checkOutput("refall_flag", int'(flag_a), 0);

        // Fresh reset, three pulses, then a fourth rise held for 10 cycles.
        @(negedge clk) reset_weight_flip = 1'b1;
        @(negedge clk) reset_weight_flip = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("three_count", int'(count_a), 3);
        @(negedge clk) weight_flip = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("hold_count", int'(count_a), 4);
        checkOutput("hold_flag", int'(flag_a), 0);

        // Release, then the fifth event trips the flag.
        weight_flip = 1'b0;
        repeat (1 + EXTRA_LAT) @(negedge clk);
        checkOutput("fall_no_count", int'(count_a), 4);
        applyStimulus();
        checkOutput("fifth_count", int'(count_a), 5);
        checkOutput("fifth_flag", int'(flag_a), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
